load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Read-side counterpart to the byte-enable store path of the data memory.
- Accepts one load from the M stage and checks alignment and address range.
- Issues a word read on the memory/peripheral bus with a req/ack handshake, then extracts and sign- or zero-extends the addressed byte or half.
- Raises AdEL (code 4) or DBE (code 7) toward CP0 and stalls the pipeline while a load is outstanding.

Parameters:
- DM_TOP, 32'h0000_2FFF, last valid data-memory byte address (DM region starts at 0).
- TMR0_BASE, 32'h0000_7F00, timer0 register window base (12 bytes).
- TMR1_BASE, 32'h0000_7F10, timer1 register window base (12 bytes).
- TIMEOUT_CYCLES, 16, cycles in REQ with no ack before DBE (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ld_req  in  1  load request from M stage; sampled in IDLE only
- ld_op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU; 5-7 are treated as LW
- ld_addr  in  32  byte address
- ld_pc  in  32  PC of the load instruction
- flush  in  1  exception/eret flush; kills the current load
- bus_rd_req  out  1  read request; held until ack
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_rd_ack  in  1  one-cycle acknowledge; bus_rd_data valid in the same cycle
- bus_rd_data  in  32  read word
- ld_busy  out  1  pipeline stall
- ld_valid  out  1  one-cycle pulse; ld_data is valid with it
- ld_data  out  32  extended result
- exc_valid  out  1  one-cycle exception pulse
- exc_code  out  5  4=AdEL, 7=DBE
- exc_pc  out  32  PC of the faulting load
- exc_badvaddr  out  32  faulting byte address

Behaviour:
- Reset values: all registered outputs 0; state IDLE; timeout counter 0.
- States: IDLE, REQ, DONE, EXC, DRAIN.
- IDLE:
  - If ld_req and !flush, latch op, addr and pc, then check the request.
  - AdEL conditions: LW with addr[1:0]!=0; LH/LHU with addr[0]!=0; addr outside [0,DM_TOP] and outside both timer windows; LH/LHU/LB/LBU to a timer window.
  - AdEL → EXC. Otherwise → REQ.
- REQ: bus_rd_req=1 with bus_addr stable.
  - On bus_rd_ack: register the extracted data → DONE.
  - On flush with no ack: → DRAIN.
  - On flush together with ack: discard the data → IDLE.
- DONE: ld_valid=1 for exactly one cycle → IDLE. A flush in DONE suppresses ld_valid.
- EXC: exc_valid=1 with exc_code, exc_pc and exc_badvaddr for one cycle → IDLE. A flush in EXC suppresses the pulse.
- DRAIN: bus_rd_req stays 1 until ack; the data is discarded; no pulse; → IDLE.
- ld_busy = ld_req | (state != IDLE). It is combinational so the stall takes effect in the request cycle.
- Latency: request at cycle t, bus_rd_req from t+1; with ack at t+1, ld_valid at t+2. Minimum load latency is 2 cycles; each bus wait cycle adds 1.
- Extraction:
  - LW returns the whole word.
  - LH/LHU select the half addr[1] ? [31:16] : [15:0].
  - LB/LBU select byte lane addr[1:0] (lane 0 = [7:0]).
  - LH/LB sign-extend; LHU/LBU zero-extend.
- ld_req is ignored outside IDLE; the pipeline holds it because of ld_busy.
- bus_rd_ack outside REQ/DRAIN is ignored.
- Reset in any state forces IDLE on the next edge and drops bus_rd_req.

Optional Feature:
- Macro LOAD_TIMEOUT_EN.
- Defined: a counter clears on entering REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, the unit goes to EXC with code 7 (DBE), exc_badvaddr=addr, and drops bus_rd_req. The counter does not run in DRAIN.
- Undefined: no counter; REQ waits indefinitely; code 7 is never produced.

Decomposition:
- Package load_pkg holds:
  - ld_op encodings
  - EXC_ADEL=4, EXC_DBE=7
  - the state enum
  - the address-map constants
- One natural sub-module, load_extend: purely combinational (word, addr[1:0], op) → extended data. It is reused by the verification model.

Test Plan:
- DM word 0x8 = 0x80FF_7F01. LB at 0xB → ld_data 0xFFFF_FF80. LBU at 0xB → 0x0000_0080. LH at 0xA → 0xFFFF_80FF. LHU at 0x8 → 0x0000_7F01. Each with ld_valid exactly 2 cycles after ld_req when ack is immediate.
- LW at 0x6, LH at 0x3, LW at 0x3000, LB at 0x7F04 → each gives exc_valid with exc_code 4, exc_badvaddr equal to the address, exc_pc=ld_pc, and bus_rd_req never asserted.
- LW at 0x7F08 with ack delayed 3 cycles → ld_busy high throughout, bus_addr stable at 0x7F08, ld_valid on the cycle after ack.
- Flush asserted 1 cycle into REQ, ack 2 cycles later with 0xDEAD_BEEF → no ld_valid, bus_rd_req held until ack, back in IDLE; a following LW returns the correct data.
- With LOAD_TIMEOUT_EN and no ack → exc_code 7 after 16 REQ cycles and bus_rd_req deasserted. Without the macro → still waiting after 100 cycles.
- Reset mid-REQ → bus_rd_req, ld_busy, ld_valid and exc_valid all 0 on the next edge.

Source files
------------

// File: rtl/load_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : load_pkg
//  Brief    : Shared encodings, exception codes, FSM states and address map
//             for the load unit.
//  Revision : 1.0  initial release
// ============================================================================
package load_pkg;

  // ld_op encodings; values above OP_LBU behave as OP_LW
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;

  // CP0 exception codes
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // Address map defaults
  localparam logic [31:0] LD_DM_TOP    = 32'h0000_2FFF;
  localparam logic [31:0] LD_TMR0_BASE = 32'h0000_7F00;
  localparam logic [31:0] LD_TMR1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TMR_SPAN     = 32'd12;

  // Bus wait limit for the optional timeout
  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DONE  = 3'd2,
    S_EXC   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Fold reserved opcodes onto LW
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    return (op > OP_LBU) ? OP_LW : op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Brief    : Combinational byte/half selection and sign/zero extension of a
//             read word according to the load opcode and low address bits.
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  sel,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Pick the addressed half/byte lane, then extend per opcode
  always_comb begin
    w_half = sel[1] ? word[31:16] : word[15:0];
    case (sel)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    case (op)
      OP_LH:   data = {{16{w_half[15]}}, w_half};
      OP_LHU:  data = {16'h0000, w_half};
      OP_LB:   data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  data = {24'h00_0000, w_byte};
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Brief    : M-stage load path. Checks alignment and address range, reads a
//             word over a req/ack bus, extends the addressed byte/half and
//             reports AdEL/DBE to CP0. Stalls the pipeline while busy.
//  Options  : LOAD_TIMEOUT_EN - raise DBE when the bus does not acknowledge
//             within TIMEOUT_CYCLES cycles of REQ.
//  Revision : 1.0  initial release
// ============================================================================
module load_unit
  import load_pkg::*;
#(
  parameter logic [31:0] DM_TOP    = LD_DM_TOP,
  parameter logic [31:0] TMR0_BASE = LD_TMR0_BASE,
  parameter logic [31:0] TMR1_BASE = LD_TMR1_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [2:0]  ld_op,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_pc,
  input  logic        flush,
  output logic        bus_rd_req,
  output logic [31:0] bus_addr,
  input  logic        bus_rd_ack,
  input  logic [31:0] bus_rd_data,
  output logic        ld_busy,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_badvaddr
);

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [2:0]  w_op;
  logic        w_in_dm;
  logic        w_in_tmr;
  logic        w_misaligned;
  logic        w_adel;
  logic [31:0] w_ext;

`ifdef LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  assign w_op = norm_op(ld_op);

  // Classify the incoming request: region membership and alignment
  always_comb begin
    w_in_dm  = (ld_addr <= DM_TOP);
    w_in_tmr = ((ld_addr >= TMR0_BASE) && (ld_addr < TMR0_BASE + TMR_SPAN)) ||
               ((ld_addr >= TMR1_BASE) && (ld_addr < TMR1_BASE + TMR_SPAN));
    case (w_op)
      OP_LW:         w_misaligned = |ld_addr[1:0];
      OP_LH, OP_LHU: w_misaligned = ld_addr[0];
      default:       w_misaligned = 1'b0;
    endcase
    // Timer registers are word-only
    w_adel = w_misaligned || (!w_in_dm && !w_in_tmr) || (w_in_tmr && (w_op != OP_LW));
  end

  load_extend u_extend (
    .word (bus_rd_data),
    .sel  (r_addr[1:0]),
    .op   (r_op),
    .data (w_ext)
  );

  // DRAIN keeps the request up so the bus transaction completes cleanly
  assign bus_rd_req = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign bus_addr   = {r_addr[31:2], 2'b00};
  // Combinational so the stall applies in the request cycle itself
  assign ld_busy    = ld_req || (r_state != S_IDLE);
  // A flush landing on the result cycle cancels the pulse
  assign ld_valid   = (r_state == S_DONE) && !flush;
  assign exc_valid  = (r_state == S_EXC) && !flush;

  // Load sequencing FSM with registered result and exception fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= OP_LW;
      r_addr       <= 32'h0;
      ld_data      <= 32'h0;
      exc_code     <= 5'd0;
      exc_pc       <= 32'h0;
      exc_badvaddr <= 32'h0;
`ifdef LOAD_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_req && !flush) begin
            r_op         <= w_op;
            r_addr       <= ld_addr;
            // exc_pc/exc_badvaddr double as the pc/address latch
            exc_pc       <= ld_pc;
            exc_badvaddr <= ld_addr;
            if (w_adel) begin
              exc_code <= EXC_ADEL;
              r_state  <= S_EXC;
            end else begin
              r_state  <= S_REQ;
`ifdef LOAD_TIMEOUT_EN
              r_cnt    <= '0;
`endif
            end
          end
        end
        S_REQ: begin
          if (bus_rd_ack) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              ld_data <= w_ext;
              r_state <= S_DONE;
            end
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            exc_code <= EXC_DBE;
            r_state  <= S_EXC;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        S_EXC:   r_state <= S_IDLE;
        S_DRAIN: if (bus_rd_ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_unit
//  Brief    : Directed self-checking bench for load_unit.
//  Options  : LOAD_TIMEOUT_EN selects the timeout scenario variant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_unit;
  import load_pkg::*;

  logic        clk;
  logic        reset;
  logic        ld_req;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic [31:0] ld_pc;
  logic        flush;
  logic        bus_rd_req;
  logic [31:0] bus_addr;
  logic        bus_rd_ack;
  logic [31:0] bus_rd_data;
  logic        ld_busy;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_badvaddr;

  int n_pass  = 0;
  int n_total = 0;

  load_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ld_req       (ld_req),
    .ld_op        (ld_op),
    .ld_addr      (ld_addr),
    .ld_pc        (ld_pc),
    .flush        (flush),
    .bus_rd_req   (bus_rd_req),
    .bus_addr     (bus_addr),
    .bus_rd_ack   (bus_rd_ack),
    .bus_rd_data  (bus_rd_data),
    .ld_busy      (ld_busy),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_badvaddr (exc_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one load and act as the bus slave; acks on the (delay+1)-th REQ cycle.
  // Cycle 0 is the request cycle; outputs are sampled on the falling edge.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] pc,
                          input logic [31:0] word, input int delay,
                          output int valid_cyc, output logic [31:0] data,
                          output int exc_cyc, output logic [4:0] code,
                          output logic [31:0] epc, output logic [31:0] bad,
                          output bit saw_req, output bit busy_ok, output bit addr_ok);
    int waits;
    waits = 0; valid_cyc = -1; exc_cyc = -1; data = '0; code = '0; epc = '0; bad = '0;
    saw_req = 0; busy_ok = 1; addr_ok = 1;
    @(posedge clk); #1;
    ld_req = 1'b1; ld_op = op; ld_addr = addr; ld_pc = pc;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!ld_busy) busy_ok = 0;
      if (ld_valid) begin valid_cyc = c; data = ld_data; end
      if (exc_valid) begin exc_cyc = c; code = exc_code; epc = exc_pc; bad = exc_badvaddr; end
      if (bus_rd_req) begin
        saw_req = 1;
        if (bus_addr !== {addr[31:2], 2'b00}) addr_ok = 0;
        if (waits == delay) begin bus_rd_ack = 1'b1; bus_rd_data = word; end
        waits++;
      end
      if (valid_cyc >= 0 || exc_cyc >= 0) break;
      @(posedge clk); #1;
      ld_req = 1'b0; bus_rd_ack = 1'b0; bus_rd_data = 32'h0;
    end
    @(posedge clk); #1;
    ld_req = 1'b0; bus_rd_ack = 1'b0; bus_rd_data = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (ld_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ld_busy); else n_pass++;
    n_total++; if (bus_rd_req !== 1'b0) $display("FAIL reset_bus_req: got %b expected 0", bus_rd_req); else n_pass++;
    n_total++; if (ld_valid !== 1'b0 || exc_valid !== 1'b0)
      $display("FAIL reset_pulses: got valid=%b exc=%b expected 0 0", ld_valid, exc_valid); else n_pass++;
    n_total++; if (ld_data !== 32'h0 || exc_code !== 5'd0 || exc_pc !== 32'h0 || exc_badvaddr !== 32'h0)
      $display("FAIL reset_regs: got data=%h code=%0d pc=%h bad=%h expected all 0",
               ld_data, exc_code, exc_pc, exc_badvaddr); else n_pass++;
    @(posedge clk); #1; reset = 1'b0;
    // A stray ack in IDLE must do nothing
    bus_rd_ack = 1'b1; bus_rd_data = 32'h5555_AAAA;
    @(posedge clk); #1; bus_rd_ack = 1'b0;
    @(negedge clk);
    n_total++; if (ld_valid !== 1'b0 || ld_busy !== 1'b0 || bus_rd_req !== 1'b0)
      $display("FAIL idle_ack_ignored: got valid=%b busy=%b req=%b expected 0 0 0",
               ld_valid, ld_busy, bus_rd_req); else n_pass++;
  endtask

  task automatic test_extract();
    logic [2:0]  ops  [11] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB, OP_LB, OP_LHU, 3'd5, OP_LH, OP_LB};
    logic [31:0] adrs [11] = '{32'hB, 32'hB, 32'hA, 32'h8, 32'h8, 32'h8, 32'h9, 32'hA, 32'h8, 32'h8, 32'hA};
    logic [31:0] exps [11] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01, 32'h0000_0001, 32'h0000_007F, 32'h0000_80FF,
                               32'h80FF_7F01, 32'h0000_7F01, 32'hFFFF_FFFF};
    int vc, ec; logic [31:0] d, epc, bad; logic [4:0] code; bit sr, bo, ao;
    for (int i = 0; i < 11; i++) begin
      run_load(ops[i], adrs[i], 32'h0040_0000 + i * 4, 32'h80FF_7F01, 0, vc, d, ec, code, epc, bad, sr, bo, ao);
      n_total++; if (d !== exps[i] || ec != -1)
        $display("FAIL extract_%0d: got data=%h exc_cyc=%0d expected data=%h no exc", i, d, ec, exps[i]); else n_pass++;
      n_total++; if (vc != 2)
        $display("FAIL latency_%0d: got ld_valid at cycle %0d expected 2", i, vc); else n_pass++;
    end
  endtask

  task automatic test_adel();
    logic [2:0]  ops  [6] = '{OP_LW, OP_LH, OP_LW, OP_LB, OP_LW, OP_LHU};
    logic [31:0] adrs [6] = '{32'h6, 32'h3, 32'h3000, 32'h7F04, 32'h7F1C, 32'h1};
    int vc, ec; logic [31:0] d, epc, bad; logic [4:0] code; bit sr, bo, ao;
    for (int i = 0; i < 6; i++) begin
      run_load(ops[i], adrs[i], 32'h0040_1000 + i * 8, 32'h1234_5678, 0, vc, d, ec, code, epc, bad, sr, bo, ao);
      n_total++; if (ec != 1 || code !== EXC_ADEL)
        $display("FAIL adel_code_%0d: got exc_cyc=%0d code=%0d expected cycle 1 code 4", i, ec, code); else n_pass++;
      n_total++; if (bad !== adrs[i] || epc !== 32'h0040_1000 + i * 8)
        $display("FAIL adel_info_%0d: got bad=%h pc=%h expected bad=%h pc=%h",
                 i, bad, epc, adrs[i], 32'h0040_1000 + i * 8); else n_pass++;
      n_total++; if (sr || vc != -1)
        $display("FAIL adel_nobus_%0d: got saw_req=%0d valid_cyc=%0d expected 0 -1", i, sr, vc); else n_pass++;
    end
  endtask

  task automatic test_boundary();
    int vc, ec; logic [31:0] d, epc, bad; logic [4:0] code; bit sr, bo, ao;
    run_load(OP_LW, 32'h2FFC, 32'h0040_2000, 32'hA5A5_0F0F, 0, vc, d, ec, code, epc, bad, sr, bo, ao);
    n_total++; if (d !== 32'hA5A5_0F0F || vc != 2 || ec != -1)
      $display("FAIL dm_top_word: got data=%h vc=%0d ec=%0d expected a5a50f0f 2 -1", d, vc, ec); else n_pass++;
    run_load(OP_LW, 32'h7F18, 32'h0040_2004, 32'h0000_0042, 0, vc, d, ec, code, epc, bad, sr, bo, ao);
    n_total++; if (d !== 32'h0000_0042 || vc != 2 || !ao)
      $display("FAIL tmr1_last_word: got data=%h vc=%0d addr_ok=%0d expected 00000042 2 1", d, vc, ao); else n_pass++;
  endtask

  task automatic test_wait_states();
    int vc, ec; logic [31:0] d, epc, bad; logic [4:0] code; bit sr, bo, ao;
    run_load(OP_LW, 32'h7F08, 32'h0040_3000, 32'h1234_5678, 3, vc, d, ec, code, epc, bad, sr, bo, ao);
    n_total++; if (vc != 5 || d !== 32'h1234_5678)
      $display("FAIL wait_result: got cycle=%0d data=%h expected 5 12345678", vc, d); else n_pass++;
    n_total++; if (!bo || !ao)
      $display("FAIL wait_stall: got busy_ok=%0d addr_ok=%0d expected 1 1", bo, ao); else n_pass++;
  endtask

  task automatic test_flush();
    int vc, ec; logic [31:0] d, epc, bad; logic [4:0] code; bit sr, bo, ao;
    bit any_valid;
    any_valid = 0;
    // Flush in the first REQ cycle, ack two cycles later
    @(posedge clk); #1; ld_req = 1'b1; ld_op = OP_LW; ld_addr = 32'h10; ld_pc = 32'h0040_4000;
    @(posedge clk); #1; ld_req = 1'b0; flush = 1'b1;
    @(negedge clk); if (ld_valid) any_valid = 1;
    n_total++; if (bus_rd_req !== 1'b1) $display("FAIL flush_req_c1: got %b expected 1", bus_rd_req); else n_pass++;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk); if (ld_valid) any_valid = 1;
    n_total++; if (bus_rd_req !== 1'b1 || ld_busy !== 1'b1)
      $display("FAIL drain_hold: got req=%b busy=%b expected 1 1", bus_rd_req, ld_busy); else n_pass++;
    @(posedge clk); #1; bus_rd_ack = 1'b1; bus_rd_data = 32'hDEAD_BEEF;
    @(negedge clk); if (ld_valid) any_valid = 1;
    n_total++; if (bus_rd_req !== 1'b1) $display("FAIL drain_req_at_ack: got %b expected 1", bus_rd_req); else n_pass++;
    @(posedge clk); #1; bus_rd_ack = 1'b0; bus_rd_data = 32'h0;
    @(negedge clk); if (ld_valid) any_valid = 1;
    n_total++; if (bus_rd_req !== 1'b0 || ld_busy !== 1'b0 || any_valid)
      $display("FAIL drain_exit: got req=%b busy=%b any_valid=%0d expected 0 0 0", bus_rd_req, ld_busy, any_valid); else n_pass++;
    run_load(OP_LW, 32'h20, 32'h0040_4004, 32'hCAFE_F00D, 0, vc, d, ec, code, epc, bad, sr, bo, ao);
    n_total++; if (d !== 32'hCAFE_F00D || vc != 2)
      $display("FAIL after_drain: got data=%h vc=%0d expected cafef00d 2", d, vc); else n_pass++;

    // Flush together with ack: data discarded, straight back to IDLE
    @(posedge clk); #1; ld_req = 1'b1; ld_op = OP_LW; ld_addr = 32'h14;
    @(posedge clk); #1; ld_req = 1'b0; flush = 1'b1; bus_rd_ack = 1'b1; bus_rd_data = 32'h1111_2222;
    @(posedge clk); #1; flush = 1'b0; bus_rd_ack = 1'b0;
    @(negedge clk);
    n_total++; if (ld_valid !== 1'b0 || bus_rd_req !== 1'b0 || ld_busy !== 1'b0)
      $display("FAIL flush_with_ack: got valid=%b req=%b busy=%b expected 0 0 0", ld_valid, bus_rd_req, ld_busy); else n_pass++;

    // Flush on the DONE cycle suppresses ld_valid
    @(posedge clk); #1; ld_req = 1'b1; ld_op = OP_LW; ld_addr = 32'h18;
    @(posedge clk); #1; ld_req = 1'b0; bus_rd_ack = 1'b1; bus_rd_data = 32'h3333_4444;
    @(posedge clk); #1; bus_rd_ack = 1'b0; flush = 1'b1;
    @(negedge clk);
    n_total++; if (ld_valid !== 1'b0) $display("FAIL flush_done: got valid=%b expected 0", ld_valid); else n_pass++;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_total++; if (ld_valid !== 1'b0 || ld_busy !== 1'b0)
      $display("FAIL flush_done_exit: got valid=%b busy=%b expected 0 0", ld_valid, ld_busy); else n_pass++;

    // Flush on the EXC cycle suppresses exc_valid
    @(posedge clk); #1; ld_req = 1'b1; ld_op = OP_LW; ld_addr = 32'h6;
    @(posedge clk); #1; ld_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    n_total++; if (exc_valid !== 1'b0) $display("FAIL flush_exc: got exc_valid=%b expected 0", exc_valid); else n_pass++;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_total++; if (exc_valid !== 1'b0 || ld_busy !== 1'b0)
      $display("FAIL flush_exc_exit: got exc=%b busy=%b expected 0 0", exc_valid, ld_busy); else n_pass++;
  endtask

  task automatic test_timeout();
`ifdef LOAD_TIMEOUT_EN
    int vc, ec; logic [31:0] d, epc, bad; logic [4:0] code; bit sr, bo, ao;
    run_load(OP_LW, 32'h40, 32'h0040_5000, 32'h0, 1000, vc, d, ec, code, epc, bad, sr, bo, ao);
    n_total++; if (ec != 17 || code !== EXC_DBE)
      $display("FAIL timeout_dbe: got exc_cyc=%0d code=%0d expected 17 7", ec, code); else n_pass++;
    n_total++; if (bad !== 32'h40 || epc !== 32'h0040_5000 || vc != -1)
      $display("FAIL timeout_info: got bad=%h pc=%h vc=%0d expected 00000040 00405000 -1", bad, epc, vc); else n_pass++;
    @(negedge clk);
    n_total++; if (bus_rd_req !== 1'b0 || ld_busy !== 1'b0)
      $display("FAIL timeout_exit: got req=%b busy=%b expected 0 0", bus_rd_req, ld_busy); else n_pass++;
`else
    bit any_exc;
    any_exc = 0;
    @(posedge clk); #1; ld_req = 1'b1; ld_op = OP_LW; ld_addr = 32'h40; ld_pc = 32'h0040_5000;
    @(posedge clk); #1; ld_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); if (exc_valid || ld_valid) any_exc = 1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++; if (bus_rd_req !== 1'b1 || ld_busy !== 1'b1 || any_exc)
      $display("FAIL no_timeout: got req=%b busy=%b pulse=%0d expected 1 1 0", bus_rd_req, ld_busy, any_exc); else n_pass++;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; bus_rd_ack = 1'b1; bus_rd_data = 32'h0;
    @(posedge clk); #1; bus_rd_ack = 1'b0;
    @(negedge clk);
    n_total++; if (ld_busy !== 1'b0) $display("FAIL no_timeout_drain: got busy=%b expected 0", ld_busy); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_req();
    int vc, ec; logic [31:0] d, epc, bad; logic [4:0] code; bit sr, bo, ao;
    @(posedge clk); #1; ld_req = 1'b1; ld_op = OP_LW; ld_addr = 32'h44; ld_pc = 32'h0040_6000;
    @(posedge clk); #1; ld_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_total++; if (bus_rd_req !== 1'b1) $display("FAIL mid_req_before: got req=%b expected 1", bus_rd_req); else n_pass++;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    n_total++; if (bus_rd_req !== 1'b0 || ld_busy !== 1'b0 || ld_valid !== 1'b0 || exc_valid !== 1'b0)
      $display("FAIL mid_req_reset: got req=%b busy=%b valid=%b exc=%b expected 0 0 0 0",
               bus_rd_req, ld_busy, ld_valid, exc_valid); else n_pass++;
    run_load(OP_LBU, 32'h45, 32'h0040_6004, 32'h0000_9A00, 0, vc, d, ec, code, epc, bad, sr, bo, ao);
    n_total++; if (d !== 32'h0000_009A || vc != 2)
      $display("FAIL after_reset_load: got data=%h vc=%0d expected 0000009a 2", d, vc); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; ld_req = 1'b0; ld_op = OP_LW; ld_addr = 32'h0; ld_pc = 32'h0;
    flush = 1'b0; bus_rd_ack = 1'b0; bus_rd_data = 32'h0;
    test_reset();
    test_extract();
    test_adel();
    test_boundary();
    test_wait_states();
    test_flush();
    test_timeout();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
